// File: rtl/snn_tdm_layer.sv
// Time-multiplexed fully-connected LIF spiking layer.
// One synapse is evaluated per clock; a start pulse runs one full timestep
// over all NOUT x NIN synapses and ends with a single-cycle done pulse.
module snn_tdm_layer #(
  parameter int unsigned NIN     = 4,
  parameter int unsigned NOUT    = 2,
  parameter int unsigned WW      = 8,
  parameter int unsigned VW      = 16,
  parameter int unsigned LEAK_SH = 3,
  parameter int unsigned REFRAC  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NIN-1:0]                in_spike,
  input  logic [VW-1:0]                 threshold,
  input  logic                          w_we,
  input  logic [$clog2(NIN*NOUT)-1:0]   w_addr,
  input  logic [WW-1:0]                 w_data,
  output logic                          busy,
  output logic                          done,
  output logic [NOUT-1:0]               out_spike
);

  localparam int unsigned NW = NIN * NOUT;
  localparam int unsigned KW = $clog2(NW);
  localparam int unsigned IW = (NIN > 1) ? $clog2(NIN) : 1;
  localparam int unsigned JW = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam int unsigned AW = WW + $clog2(NIN) + 1;
  localparam int unsigned XW = VW + 2;
  localparam int unsigned RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  // Saturation bounds of the membrane potential, expressed in the wide domain
  localparam logic signed [XW-1:0] VMAX = {3'b000, {(VW-1){1'b1}}};
  localparam logic signed [XW-1:0] VMIN = {3'b111, {(VW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FIRE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [WW-1:0]        w_mem [NW];
  logic signed [VW-1:0] v     [NOUT];
  logic [RW-1:0]        rc    [NOUT];

  logic [NIN-1:0]        spk_l;
  logic signed [VW-1:0]  thr_l;
  logic signed [AW-1:0]  acc;
  logic [IW-1:0]         i_idx;
  logic [JW-1:0]         j_idx;
  logic [KW-1:0]         k_idx;
  logic [NOUT-1:0]       spk_vec;

  logic                  last_i;
  logic                  last_j;
  logic signed [WW-1:0]  w_cur;
  logic signed [AW-1:0]  acc_sum;
  logic signed [VW-1:0]  v_cur;
  logic [RW-1:0]         rc_cur;
  logic signed [XW-1:0]  vn_wide;
  logic signed [VW-1:0]  vn_sat;
  logic                  fire_now;
  logic [NOUT-1:0]       spk_next;
  logic                  addr_ok;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = ACC;
      ACC:     if (last_i && last_j) state_n = FIRE;
      FIRE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Synapse accumulate and neuron update arithmetic for the current (j,i)
  always_comb begin
    last_i   = (i_idx == IW'(NIN - 1));
    last_j   = (j_idx == JW'(NOUT - 1));
    w_cur    = w_mem[k_idx];
    acc_sum  = spk_l[i_idx] ? (acc + AW'(w_cur)) : acc;
    v_cur    = v[j_idx];
    rc_cur   = rc[j_idx];
    vn_wide  = XW'(v_cur) - XW'(v_cur >>> LEAK_SH) + XW'(acc_sum);
    if (vn_wide > VMAX)      vn_sat = VW'(VMAX);
    else if (vn_wide < VMIN) vn_sat = VW'(VMIN);
    else                     vn_sat = VW'(vn_wide);
    fire_now = (rc_cur == '0) && (vn_sat >= thr_l);
    spk_next = spk_vec;
    spk_next[j_idx] = fire_now;
    addr_ok  = ({1'b0, w_addr} < (KW+1)'(NW));
  end

  // Weight memory, input latches, accumulator and per-neuron state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned n = 0; n < NW; n++)   w_mem[KW'(n)] <= '0;
      for (int unsigned n = 0; n < NOUT; n++) begin
        v[JW'(n)]  <= '0;
        rc[JW'(n)] <= '0;
      end
      spk_l   <= '0;
      thr_l   <= '0;
      acc     <= '0;
      i_idx   <= '0;
      j_idx   <= '0;
      k_idx   <= '0;
      spk_vec <= '0;
    end else begin
      if (state == IDLE && w_we && addr_ok) w_mem[w_addr] <= w_data;
      case (state)
        IDLE: begin
          if (start) begin
            spk_l <= in_spike;
            thr_l <= threshold;
            acc   <= '0;
            i_idx <= '0;
            j_idx <= '0;
            k_idx <= '0;
          end
        end
        ACC: begin
          k_idx <= k_idx + KW'(1);
          if (last_i) begin
            acc            <= '0;
            i_idx          <= '0;
            j_idx          <= j_idx + JW'(1);
            spk_vec[j_idx] <= fire_now;
            if (rc_cur != '0) begin
              v[j_idx]  <= '0;
              rc[j_idx] <= rc_cur - RW'(1);
            end else if (fire_now) begin
              v[j_idx]  <= '0;
              rc[j_idx] <= RW'(REFRAC);
            end else begin
              v[j_idx]  <= vn_sat;
            end
          end else begin
            acc   <= acc_sum;
            i_idx <= i_idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs; spike vector is committed as the FSM enters FIRE
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      out_spike <= '0;
    end else begin
      busy <= (state_n != IDLE);
      done <= (state_n == FIRE);
      if (state == ACC && last_i && last_j) out_spike <= spk_next;
    end
  end

endmodule

// File: tb/tb_snn_tdm_layer.sv
// Directed self-checking bench for snn_tdm_layer: default instance plus a
// narrow-potential, non-power-of-two instance for saturation and address range.
module tb_snn_tdm_layer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: NIN=4 NOUT=2 VW=16 REFRAC=2
  logic        a_start = 1'b0;
  logic [3:0]  a_in    = '0;
  logic [15:0] a_thr   = '0;
  logic        a_we    = 1'b0;
  logic [2:0]  a_addr  = '0;
  logic [7:0]  a_data  = '0;
  logic        a_busy, a_done;
  logic [1:0]  a_out;

  snn_tdm_layer u_a (
    .clk(clk), .rst(rst), .start(a_start), .in_spike(a_in), .threshold(a_thr),
    .w_we(a_we), .w_addr(a_addr), .w_data(a_data),
    .busy(a_busy), .done(a_done), .out_spike(a_out)
  );

  // Instance B: NIN=3 NOUT=2 VW=10 REFRAC=0
  logic       b_start = 1'b0;
  logic [2:0] b_in    = '0;
  logic [9:0] b_thr   = '0;
  logic       b_we    = 1'b0;
  logic [2:0] b_addr  = '0;
  logic [7:0] b_data  = '0;
  logic       b_busy, b_done;
  logic [1:0] b_out;

  snn_tdm_layer #(.NIN(3), .NOUT(2), .WW(8), .VW(10), .LEAK_SH(3), .REFRAC(0)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .in_spike(b_in), .threshold(b_thr),
    .w_we(b_we), .w_addr(b_addr), .w_data(b_data),
    .busy(b_busy), .done(b_done), .out_spike(b_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input int addr, input int data);
    a_we = 1'b1; a_addr = 3'(addr); a_data = 8'(data);
    tick();
    a_we = 1'b0;
  endtask

  task automatic wr_b(input int addr, input int data);
    b_we = 1'b1; b_addr = 3'(addr); b_data = 8'(data);
    tick();
    b_we = 1'b0;
  endtask

  // Pulse start, return spike vector and the cycle (1 = first after start) done was seen
  task automatic step_a(input logic [3:0] ins, input int thr, output logic [1:0] spk, output int lat);
    a_in = ins; a_thr = 16'(thr); a_start = 1'b1;
    tick();
    a_start = 1'b0; a_we = 1'b0;
    lat = 0; spk = 2'b11;
    for (int n = 1; n <= 40; n++) begin
      if (a_done) begin lat = n; spk = a_out; break; end
      tick();
    end
    tick();
  endtask

  task automatic step_b(input logic [2:0] ins, input int thr, output logic [1:0] spk, output int lat);
    b_in = ins; b_thr = 10'(thr); b_start = 1'b1;
    tick();
    b_start = 1'b0;
    lat = 0; spk = 2'b11;
    for (int n = 1; n <= 40; n++) begin
      if (b_done) begin lat = n; spk = b_out; break; end
      tick();
    end
    tick();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [1:0] spk;
  int lat;
  int ndone;
  logic [1:0] exp3 [6];
  logic [1:0] expr [4];

  initial begin
    // Reset with start held high: reset must win
    a_start = 1'b1;
    tick(); tick();
    rst = 1'b0; a_start = 1'b0;
    check("rst_busy", 32'(a_busy), 0);
    check("rst_done", 32'(a_done), 0);
    check("rst_out",  32'(a_out),  0);

    // Zero weights never fire
    step_a(4'b1111, 1, spk, lat);
    check("t1_lat", 32'(lat), 9);
    check("t1_out", 32'(spk), 0);

    // Single fire; w[1] written in the same cycle as start
    wr_a(0, 60);
    a_we = 1'b1; a_addr = 3'd1; a_data = 8'd50;
    step_a(4'b0011, 100, spk, lat);
    check("t2_lat", 32'(lat), 9);
    check("t2_out", 32'(spk), 1);

    // Leak and refractory: 64, 120 fire, refrac, refrac, 64, 120 fire
    pulse_rst();
    wr_a(0, 64);
    exp3[0] = 2'b00; exp3[1] = 2'b01; exp3[2] = 2'b00;
    exp3[3] = 2'b00; exp3[4] = 2'b00; exp3[5] = 2'b01;
    for (int s = 0; s < 6; s++) begin
      step_a(4'b0001, 100, spk, lat);
      check($sformatf("t3_s%0d", s + 1), 32'(spk), 32'(exp3[s]));
    end

    // Protocol: start, weight write, input changes all ignored while busy
    pulse_rst();
    wr_a(0, 60);
    wr_a(1, 50);
    a_in = 4'b0011; a_thr = 16'd100; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick(); tick();
    a_start = 1'b1; a_we = 1'b1; a_addr = 3'd0; a_data = 8'd127;
    a_in = 4'b0000; a_thr = 16'd1000;
    tick();
    a_start = 1'b0; a_we = 1'b0;
    ndone = 0; lat = 0; spk = 2'b11;
    for (int n = 4; n <= 30; n++) begin
      if (a_done) begin
        ndone++;
        if (lat == 0) begin lat = n; spk = a_out; end
      end
      tick();
    end
    check("t5_lat",   32'(lat),   9);
    check("t5_ndone", 32'(ndone), 1);
    check("t5_out",   32'(spk),   1);
    step_a(4'b0011, 100, spk, lat);
    check("t5_ref1", 32'(spk), 0);
    step_a(4'b0011, 100, spk, lat);
    check("t5_ref2", 32'(spk), 0);
    step_a(4'b0001, 100, spk, lat);
    check("t5_w0_kept", 32'(spk), 0);

    // Reset in cycle 4 of a firing timestep aborts it
    pulse_rst();
    wr_a(0, 60);
    wr_a(1, 50);
    a_in = 4'b0011; a_thr = 16'd100; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick(); tick(); tick();
    pulse_rst();
    check("t6_busy", 32'(a_busy), 0);
    check("t6_out",  32'(a_out),  0);
    ndone = 0;
    for (int n = 0; n < 15; n++) begin
      if (a_done) ndone++;
      tick();
    end
    check("t6_ndone", 32'(ndone), 0);
    step_a(4'b1111, 1, spk, lat);
    check("t6_lat",   32'(lat), 9);
    check("t6_fresh", 32'(spk), 0);

    // Instance B: out-of-range writes ignored, then negative saturation at -512
    wr_b(6, 127);
    wr_b(7, 127);
    wr_b(3, -128);
    wr_b(4, -128);
    wr_b(5, -128);
    for (int s = 0; s < 5; s++) begin
      step_b(3'b111, 100, spk, lat);
      if (s == 0) check("t4_lat", 32'(lat), 7);
      check($sformatf("t4_sat%0d", s + 1), 32'(spk), 0);
    end
    // Recovery from -512 with +127: -321, -153, -6, 122 (fires)
    wr_b(4, 0);
    wr_b(5, 0);
    wr_b(3, 127);
    expr[0] = 2'b00; expr[1] = 2'b00; expr[2] = 2'b00; expr[3] = 2'b10;
    for (int s = 0; s < 4; s++) begin
      step_b(3'b001, 100, spk, lat);
      check($sformatf("t4_rec%0d", s + 1), 32'(spk), 32'(expr[s]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
